// File: rtl/framebuffer_swap_ctrl.sv
// Double-buffered 320x240x3b frame store between the renderer and the VGA scan-out.
// Optional back-bank clear before each render_ack is enabled with `define FB_CLEAR_EN.
module framebuffer_swap_ctrl #(
  parameter int unsigned FB_W      = 320,
  parameter int unsigned FB_H      = 240,
  parameter logic [2:0]  SKY_COLOR = 3'd5
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [16:0] coords_in,
  input  logic [2:0]  color_in,
  input  logic        we_in,
  input  logic        render_done,
  output logic        render_ack,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        vblank_start,
  output logic [2:0]  pixel_color,
  output logic        swapped
);

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DEPTH  = FB_W * FB_H;
  localparam int unsigned SCAN_W = 2 * FB_W;
  localparam int unsigned SCAN_H = 2 * FB_H;

  typedef enum logic [1:0] {CLEAR, ACK, RENDER, WAIT_VB} state_t;

`ifdef FB_CLEAR_EN
  localparam state_t START_STATE = CLEAR;
`else
  localparam state_t START_STATE = ACK;
`endif

  state_t              state, state_next;
  logic                front_sel;
  logic                swap_c;
  logic                wr_en_c;
  logic [ADDR_W-1:0]   wr_addr_c;
  logic [2:0]          wr_data_c;
  logic [8:0]          x;
  logic [7:0]          y;
  logic                in_range_c;
  logic [ADDR_W-1:0]   pix_addr_c;
  logic [ADDR_W-1:0]   scan_addr_c;
  logic                blank_c;

  logic [2:0] bank0 [DEPTH];
  logic [2:0] bank1 [DEPTH];

  assign x          = coords_in[16:8];
  assign y          = coords_in[7:0];
  assign in_range_c = (32'(x) < FB_W) && (32'(y) < FB_H);
  assign pix_addr_c = ADDR_W'(32'(y) * FB_W + 32'(x));

  // Each scan pixel is shown twice horizontally and vertically (640x480 from 320x240)
  assign scan_addr_c = ADDR_W'(32'(DrawY >> 1) * FB_W + 32'(DrawX >> 1));
  assign blank_c     = (32'(DrawX) >= SCAN_W) || (32'(DrawY) >= SCAN_H);

`ifdef FB_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr;

  always_ff @(posedge Clk) begin
    if (Reset || swap_c)
      clr_addr <= '0;
    else if (state == CLEAR)
      clr_addr <= clr_addr + ADDR_W'(1);
  end
`else
  logic [2:0] unused_sky;
  assign unused_sky = SKY_COLOR;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= START_STATE;
      front_sel   <= 1'b0;
      render_ack  <= 1'b0;
      swapped     <= 1'b0;
    end else begin
      state       <= state_next;
      front_sel   <= front_sel ^ swap_c;
      render_ack  <= (state == ACK);
      swapped     <= swap_c;
    end
  end

  always_comb begin
    state_next = state;
    swap_c     = 1'b0;
    wr_en_c    = 1'b0;
    wr_addr_c  = '0;
    wr_data_c  = '0;
    case (state)
`ifdef FB_CLEAR_EN
      CLEAR: begin
        wr_en_c   = 1'b1;
        wr_addr_c = clr_addr;
        wr_data_c = SKY_COLOR;
        if (clr_addr == ADDR_W'(DEPTH - 1))
          state_next = ACK;
      end
`endif
      ACK: state_next = RENDER;
      RENDER: begin
        if (we_in && in_range_c) begin
          wr_en_c   = 1'b1;
          wr_addr_c = pix_addr_c;
          wr_data_c = color_in;
        end
        // A done coinciding with vblank swaps at once instead of waiting a frame
        if (render_done) begin
          if (vblank_start) begin
            swap_c     = 1'b1;
            state_next = START_STATE;
          end else begin
            state_next = WAIT_VB;
          end
        end
      end
      WAIT_VB: begin
        if (vblank_start) begin
          swap_c     = 1'b1;
          state_next = START_STATE;
        end
      end
      default: state_next = START_STATE;
    endcase
  end

  // Back bank is the one not selected for scan-out
  always_ff @(posedge Clk) begin
    if (wr_en_c && !Reset) begin
      if (front_sel)
        bank0[wr_addr_c] <= wr_data_c;
      else
        bank1[wr_addr_c] <= wr_data_c;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset || blank_c)
      pixel_color <= 3'd0;
    else if (front_sel)
      pixel_color <= bank1[scan_addr_c];
    else
      pixel_color <= bank0[scan_addr_c];
  end

endmodule

// File: tb/tb_framebuffer_swap_ctrl.sv
// Directed bench for framebuffer_swap_ctrl: ack timing, writes, swaps, scan reads, reset.
// Expectations follow FB_CLEAR_EN when it is defined for the build.
module tb_framebuffer_swap_ctrl;

`ifdef FB_CLEAR_EN
  localparam int ACK_LAT   = 76801;
  localparam int STALE_PIX = 5;
`else
  localparam int ACK_LAT   = 1;
  localparam int STALE_PIX = 3;
`endif
  localparam int ACK_BUDGET = 80000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [16:0] coords_in;
  logic [2:0]  color_in;
  logic        we_in;
  logic        render_done;
  logic        render_ack;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        vblank_start;
  logic [2:0]  pixel_color;
  logic        swapped;

  int errors = 0;
  int checks = 0;

  framebuffer_swap_ctrl dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .coords_in    (coords_in),
    .color_in     (color_in),
    .we_in        (we_in),
    .render_done  (render_done),
    .render_ack   (render_ack),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .vblank_start (vblank_start),
    .pixel_color  (pixel_color),
    .swapped      (swapped)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!render_ack && n < ACK_BUDGET);
    chk(tag, 32'(n), 32'(ACK_LAT));
  endtask

  task automatic wr_pix(input int px, input int py, input logic [2:0] c);
    coords_in = {9'(px), 8'(py)};
    color_in  = c;
    we_in     = 1'b1;
    step();
    we_in     = 1'b0;
  endtask

  task automatic rd_pix(input string tag, input int dx, input int dy, input int exp);
    DrawX = 10'(dx);
    DrawY = 10'(dy);
    step();
    chk(tag, 32'(pixel_color), 32'(exp));
  endtask

  initial begin
    Reset = 1'b1; coords_in = '0; color_in = '0; we_in = 1'b0;
    render_done = 1'b0; DrawX = '0; DrawY = '0; vblank_start = 1'b0;
    repeat (3) step();
    chk("rst_ack", 32'(render_ack), 0);
    chk("rst_swapped", 32'(swapped), 0);
    chk("rst_pixel", 32'(pixel_color), 0);
    chk("rst_front", 32'(dut.front_sel), 0);

    Reset = 1'b0;
    wait_ack("ack_after_reset");
    step();
    chk("ack_one_cycle", 32'(render_ack), 0);

    wr_pix(10, 20, 3'd3);
    wr_pix(0, 6, 3'd2);
    wr_pix(320, 5, 3'd7);
    wr_pix(5, 240, 3'd7);
    coords_in = {9'd1, 8'd1}; color_in = 3'd4; we_in = 1'b1; render_done = 1'b1;
    step();
    we_in = 1'b0; render_done = 1'b0;

    // Waiting for vblank: writes and further done pulses must be ignored
    coords_in = {9'd10, 8'd20}; color_in = 3'd6; we_in = 1'b1; render_done = 1'b1;
    step();
    we_in = 1'b0; render_done = 1'b0;
    repeat (98) step();
    chk("no_swap_before_vb", 32'(swapped), 0);
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    chk("swap_pulse", 32'(swapped), 1);
    chk("front_after_swap1", 32'(dut.front_sel), 1);
    wait_ack("ack_after_swap1");
    chk("swap_one_cycle", 32'(swapped), 0);

    rd_pix("pix_10_20", 20, 40, 3);
    rd_pix("pix_10_20_dbl", 21, 41, 3);
    rd_pix("pix_0_6", 0, 12, 2);
    rd_pix("pix_1_1_same_done", 2, 2, 4);
    rd_pix("blank_x", 700, 10, 0);
    rd_pix("blank_y", 20, 480, 0);
`ifdef FB_CLEAR_EN
    rd_pix("clr_first", 0, 0, 5);
    rd_pix("clr_last", 638, 478, 5);
`endif

    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    chk("vb_in_render_swapped", 32'(swapped), 0);
    chk("vb_in_render_front", 32'(dut.front_sel), 1);

    wr_pix(10, 20, 3'd5);
    render_done = 1'b1; vblank_start = 1'b1;
    step();
    render_done = 1'b0; vblank_start = 1'b0;
    chk("same_cycle_swap", 32'(swapped), 1);
    chk("front_after_swap2", 32'(dut.front_sel), 0);
    wait_ack("ack_after_swap2");
    rd_pix("pix_frame2", 20, 40, 5);

    render_done = 1'b1;
    step();
    render_done = 1'b0;
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    chk("swap3_pulse", 32'(swapped), 1);
    chk("front_after_swap3", 32'(dut.front_sel), 1);
    rd_pix("pix_stale", 20, 40, STALE_PIX);
`ifdef FB_CLEAR_EN
    repeat (39999) step();
    chk("clr_addr_mid", 32'(dut.clr_addr), 40000);
`endif

    Reset = 1'b1;
    step();
    chk("midrst_ack", 32'(render_ack), 0);
    chk("midrst_front", 32'(dut.front_sel), 0);
    chk("midrst_swapped", 32'(swapped), 0);
`ifdef FB_CLEAR_EN
    chk("midrst_clr_addr", 32'(dut.clr_addr), 0);
`endif
    Reset = 1'b0;
    wait_ack("ack_after_midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
